serial_tx: RTL and testbench

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_tx.sv | 122 ++++++++++++
 tb/tb_serial_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// Serial frame transmitter: start bit, DBIT data bits LSB first, optional even
// parity, one stop bit. All outputs are registered; tx idles high.
module serial_tx #(
    parameter int DBIT         = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic [DBIT-1:0] sh;
    logic            par;
    logic            bit_end;
    logic [DBIT-1:0] sh_next;

    assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));
    assign sh_next = sh >> 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            tx           <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done_tick <= 1'b0;
            cnt          <= '0;
            idx          <= '0;
            sh           <= '0;
            par          <= 1'b0;
        end else begin
            tx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_start) begin
                        sh      <= din;
                        par     <= (PARITY_EN != 0) ? ^din : 1'b0;
                        cnt     <= '0;
                        idx     <= '0;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        tx    <= sh[0];
                        state <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        sh  <= sh_next;
                        if (idx == IW'(DBIT - 1)) begin
                            idx <= '0;
                            if (PARITY_EN != 0) begin
                                tx    <= par;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                            tx  <= sh_next[0];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        tx    <= 1'b1;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    // tx is already high; the done pulse coincides with the return to IDLE
                    if (bit_end) begin
                        cnt          <= '0;
                        tx_busy      <= 1'b0;
                        tx_done_tick <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: two instances (no parity / even parity, 4 clocks per bit)
// compared every cycle against a slot-based waveform model.
module tb_serial_tx;

    localparam int DBIT = 8;
    localparam int C    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, start0, tx0, busy0, done0;
    logic       rst1, start1, tx1, busy1, done1;
    logic [7:0] din0, din1;

    int checks = 0;
    int passed = 0;

    serial_tx #(.DBIT(DBIT), .CLKS_PER_BIT(C), .PARITY_EN(0)) dut0 (
        .clk(clk), .reset(rst0), .tx_start(start0), .din(din0),
        .tx(tx0), .tx_busy(busy0), .tx_done_tick(done0)
    );

    serial_tx #(.DBIT(DBIT), .CLKS_PER_BIT(C), .PARITY_EN(1)) dut1 (
        .clk(clk), .reset(rst1), .tx_start(start1), .din(din1),
        .tx(tx1), .tx_busy(busy1), .tx_done_tick(done1)
    );

    // Expected {tx, tx_busy, tx_done_tick} in the period following edge E0+k.
    function automatic logic [2:0] model(input logic [7:0] d, input int p, input int k);
        int   n;
        int   slot;
        logic t;
        n = (DBIT + 2 + p) * C;
        if (k >= n) return {1'b1, 1'b0, (k == n)};
        slot = k / C;
        if (slot == 0)                    t = 1'b0;
        else if (slot <= DBIT)            t = d[slot-1];
        else if (p == 1 && slot == DBIT+1) t = ^d;
        else                              t = 1'b1;
        return {t, 1'b1, 1'b0};
    endfunction

    function automatic logic [2:0] obs(input int sel);
        return (sel == 1) ? {tx1, busy1, done1} : {tx0, busy0, done0};
    endfunction

    task automatic set_in(input int sel, input logic r, input logic s, input logic [7:0] d);
        if (sel == 1) begin rst1 = r; start1 = s; din1 = d; end
        else          begin rst0 = r; start0 = s; din0 = d; end
    endtask

    // Pulses tx_start for one edge (E0) and returns #1 after E0.
    task automatic launch(input int sel, input logic [7:0] d);
        @(negedge clk);
        set_in(sel, 1'b0, 1'b1, d);
        @(posedge clk);
        #1;
        set_in(sel, 1'b0, 1'b0, d);
    endtask

    task automatic test_reset();
        logic [2:0] got;
        set_in(0, 1'b1, 1'b0, 8'h00);
        set_in(1, 1'b1, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            got = obs(s);
            checks++;
            if (got !== 3'b100) $display("FAIL reset inst%0d got=%b exp=100", s, got);
            else passed++;
        end
        @(negedge clk);
        set_in(0, 1'b0, 1'b0, 8'h00);
        set_in(1, 1'b0, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_frame_a5();
        logic [2:0] got, exp;
        launch(0, 8'hA5);
        din0 = 8'h5A;
        for (int k = 0; k <= 41; k++) begin
            got = obs(0);
            exp = model(8'hA5, 0, k);
            checks++;
            if (got !== exp) $display("FAIL frame_a5 k=%0d got=%b exp=%b", k, got, exp);
            else passed++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_parity_07();
        logic [2:0] got, exp;
        launch(1, 8'h07);
        din1 = 8'hF0;
        for (int k = 0; k <= 45; k++) begin
            got = obs(1);
            exp = model(8'h07, 1, k);
            checks++;
            if (got !== exp) $display("FAIL parity_07 k=%0d got=%b exp=%b", k, got, exp);
            else passed++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random();
        logic [2:0] got, exp;
        logic [7:0] d;
        int         sel, n;
        for (int f = 0; f < 8; f++) begin
            sel = f % 2;
            d   = 8'($urandom);
            n   = (DBIT + 2 + sel) * C;
            launch(sel, d);
            set_in(sel, 1'b0, 1'b0, 8'($urandom));
            for (int k = 0; k <= n + 1; k++) begin
                got = obs(sel);
                exp = model(d, sel, k);
                checks++;
                if (got !== exp)
                    $display("FAIL random inst%0d d=%h k=%0d got=%b exp=%b", sel, d, k, got, exp);
                else passed++;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] got, exp;
        @(negedge clk);
        set_in(0, 1'b0, 1'b1, 8'h3C);
        @(posedge clk);
        #1;
        din0 = 8'hC3;
        for (int k = 0; k <= 40; k++) begin
            got = obs(0);
            exp = model(8'h3C, 0, k);
            checks++;
            if (got !== exp) $display("FAIL b2b_first k=%0d got=%b exp=%b", k, got, exp);
            else passed++;
            @(posedge clk);
            #1;
        end
        start0 = 1'b0;
        for (int k = 0; k <= 41; k++) begin
            got = obs(0);
            exp = model(8'hC3, 0, k);
            checks++;
            if (got !== exp) $display("FAIL b2b_second k=%0d got=%b exp=%b", k, got, exp);
            else passed++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_ignore_mid();
        logic [2:0] got, exp;
        int         dones = 0;
        launch(0, 8'h00);
        for (int k = 0; k <= 50; k++) begin
            got = obs(0);
            exp = model(8'h00, 0, k);
            if (got[0] === 1'b1) dones++;
            checks++;
            if (got !== exp) $display("FAIL ignore_mid k=%0d got=%b exp=%b", k, got, exp);
            else passed++;
            if (k == 12) begin start0 = 1'b1; din0 = 8'hFF; end
            if (k == 13) start0 = 1'b0;
            @(posedge clk);
            #1;
        end
        checks++;
        if (dones !== 1) $display("FAIL ignore_mid_dones got=%0d exp=1", dones);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [2:0] got, exp;
        logic [7:0] d;
        d = 8'($urandom);
        launch(0, d);
        for (int k = 0; k <= 16; k++) begin
            got = obs(0);
            exp = model(d, 0, k);
            checks++;
            if (got !== exp) $display("FAIL reset_mid_pre k=%0d got=%b exp=%b", k, got, exp);
            else passed++;
            if (k == 16) rst0 = 1'b1;
            @(posedge clk);
            #1;
        end
        rst0 = 1'b0;
        for (int j = 0; j < 6; j++) begin
            got = obs(0);
            checks++;
            if (got !== 3'b100) $display("FAIL reset_mid_abort j=%0d got=%b exp=100", j, got);
            else passed++;
            @(posedge clk);
            #1;
        end
        launch(0, 8'h81);
        for (int k = 0; k <= 41; k++) begin
            got = obs(0);
            exp = model(8'h81, 0, k);
            checks++;
            if (got !== exp) $display("FAIL reset_mid_new k=%0d got=%b exp=%b", k, got, exp);
            else passed++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_with_start();
        logic [2:0] got;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            set_in(s, 1'b1, 1'b1, 8'hAA);
            @(posedge clk);
            #1;
            set_in(s, 1'b0, 1'b0, 8'hAA);
            for (int j = 0; j < 6; j++) begin
                got = obs(s);
                checks++;
                if (got !== 3'b100)
                    $display("FAIL reset_with_start inst%0d j=%0d got=%b exp=100", s, j, got);
                else passed++;
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        rst0 = 1'b1; start0 = 1'b0; din0 = 8'h00;
        rst1 = 1'b1; start1 = 1'b0; din1 = 8'h00;
        test_reset();
        test_frame_a5();
        test_parity_07();
        test_random();
        test_back_to_back();
        test_ignore_mid();
        test_reset_mid();
        test_reset_with_start();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
